regbank_sequencer: RTL

Command-side master for the 32×32 register bank: accepts one three-address instruction at a time over a valid/ready handshake, drives the bank's read selects, computes the result, and issues the write-back. After every reset it clears the whole bank through the write port with an initialization sweep. It sits between an instruction source (testbench or fetch stage) and the register bank, owning all bank control signals.

---
 rtl/regbank_pkg.sv | 25 ++
 rtl/regbank_alu.sv | 32 +++
 rtl/regbank_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank sequencer: opcodes, FSM states, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regbank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_LI  = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_t;

endpackage

// File: rtl/regbank_alu.sv
// Purely combinational ALU for the sequencer: opcode + two bank operands + immediate -> result.
// Latency: zero cycles (combinational).
// Backpressure: none; the caller decides when the output is captured.
module regbank_alu
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [15:0]       imm,
  output logic [DATA_W-1:0] y
);

  // Select the operation; ADD/SUB wrap naturally, shift amount is the low five bits of b.
  always_comb begin
    y = '0;
    case (opcode)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << b[4:0];
      OP_LI:   y = {{(DATA_W-16){imm[15]}}, imm};
      OP_MOV:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regbank_sequencer.sv
// Command master for the register bank: clears the bank after reset, then runs one instruction at a time.
// Latency: accept edge A, read/ALU in A+1, write-back and done in A+2, ready again in A+3.
// Backpressure: instr_ready is high only in IDLE; a held instr_valid is consumed exactly once.
module regbank_sequencer
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [15:0]       imm,
  output logic [ADDR_W-1:0] sr1,
  output logic [ADDR_W-1:0] sr2,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2,
  output logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] wrData,
  output logic              write,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              init_done
);

  state_t            state, state_nxt;
  // One extra bit so the sweep can tell "index 31 written" from "still sweeping".
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic [2:0]        op_q, op_nxt;
  logic [ADDR_W-1:0] rd_q, rd_nxt;
  logic [15:0]       imm_q, imm_nxt;

  logic              ready_nxt, write_nxt, done_nxt, init_done_nxt;
  logic [ADDR_W-1:0] sr1_nxt, sr2_nxt, dr_nxt;
  logic [DATA_W-1:0] wrdata_nxt, result_nxt;
  logic [DATA_W-1:0] alu_y;

  regbank_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (op_q),
    .a      (rdData1),
    .b      (rdData2),
    .imm    (imm_q),
    .y      (alu_y)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    op_nxt        = op_q;
    rd_nxt        = rd_q;
    imm_nxt       = imm_q;
    ready_nxt     = 1'b0;
    write_nxt     = 1'b0;
    done_nxt      = 1'b0;
    init_done_nxt = init_done;
    sr1_nxt       = sr1;
    sr2_nxt       = sr2;
    dr_nxt        = dr;
    wrdata_nxt    = wrData;
    result_nxt    = result;
    case (state)
      ST_INIT: begin
        if (!cnt[ADDR_W]) begin
          write_nxt  = 1'b1;
          dr_nxt     = cnt[ADDR_W-1:0];
          wrdata_nxt = '0;
          cnt_nxt    = cnt + (ADDR_W+1)'(1);
        end else begin
          ready_nxt     = 1'b1;
          init_done_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (instr_valid && instr_ready) begin
          op_nxt    = opcode;
          rd_nxt    = rd;
          imm_nxt   = imm;
          sr1_nxt   = rs1;
          sr2_nxt   = rs2;
          state_nxt = ST_EXEC;
        end else begin
          ready_nxt = 1'b1;
        end
      end
      ST_EXEC: begin
        // Sources are read here, before the write-back commits, so rd==rs sees the old value.
        result_nxt = alu_y;
        wrdata_nxt = alu_y;
        dr_nxt     = rd_q;
        write_nxt  = 1'b1;
        done_nxt   = 1'b1;
        state_nxt  = ST_WB;
      end
      ST_WB: begin
        ready_nxt = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // State, latch and output registers; reset drops any in-flight instruction and restarts the sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_INIT;
      cnt         <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      instr_ready <= 1'b0;
      sr1         <= '0;
      sr2         <= '0;
      dr          <= '0;
      wrData      <= '0;
      write       <= 1'b0;
      result      <= '0;
      done        <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      op_q        <= op_nxt;
      rd_q        <= rd_nxt;
      imm_q       <= imm_nxt;
      instr_ready <= ready_nxt;
      sr1         <= sr1_nxt;
      sr2         <= sr2_nxt;
      dr          <= dr_nxt;
      wrData      <= wrdata_nxt;
      write       <= write_nxt;
      result      <= result_nxt;
      done        <= done_nxt;
      init_done   <= init_done_nxt;
    end
  end

endmodule
